// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single 8-bit ALU: grants one requester, latches its operands,
// registers the flag-sanitised result and returns it on that requester's response channel.
module alu_arbiter #(
    parameter bit ArbMode = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [2:0] req0_op_i,
    input  logic [7:0] req0_a_i,
    input  logic [7:0] req0_b_i,
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    input  logic [2:0] req1_op_i,
    input  logic [7:0] req1_a_i,
    input  logic [7:0] req1_b_i,
    output logic       rsp0_valid_o,
    input  logic       rsp0_ready_i,
    output logic       rsp1_valid_o,
    input  logic       rsp1_ready_i,
    output logic [7:0] rsp_result_o,
    output logic       rsp_cout_o,
    output logic       rsp_overflow_o,
    output logic       rsp_err_o
);

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e     state_q, state_d;
    logic       port_q;
    logic       last_q, last_d;
    logic [2:0] op_q;
    logic [7:0] a_q, b_q;
    logic [7:0] result_q;
    logic       cout_q, ovf_q, err_q;

    logic       gnt_any, gnt_port, accept, rsp_done;

    // last_q holds the port served most recently; a tie goes to the other one.
    always_comb begin
        gnt_any = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            gnt_port = ArbMode ? ~last_q : 1'b0;
        end else begin
            gnt_port = req1_valid_i;
        end
    end

    assign accept   = (state_q == StIdle) && gnt_any;
    assign rsp_done = (state_q == StResp) && (port_q ? rsp1_ready_i : rsp0_ready_i);
    assign last_d   = rsp_done ? port_q : last_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        if (state_q == StIdle) begin
            req0_ready_o = gnt_any & ~gnt_port;
            req1_ready_o = gnt_any & gnt_port;
        end
        if (state_q == StResp) begin
            rsp0_valid_o = ~port_q;
            rsp1_valid_o = port_q;
        end
    end

    assign rsp_result_o   = result_q;
    assign rsp_cout_o     = cout_q;
    assign rsp_overflow_o = ovf_q;
    assign rsp_err_o      = err_q;

    // Shared ALU: carry leaks from the adder for every opcode and is masked below.
    logic [8:0] sum9, diff9;
    logic [7:0] alu_res;
    logic       alu_cout, alu_ovf;

    always_comb begin
        sum9     = {a_q[7], a_q} + {b_q[7], b_q};
        diff9    = {a_q[7], a_q} - {b_q[7], b_q};
        alu_ovf  = (a_q[7] == b_q[7]) && (sum9[7] != a_q[7]);
        alu_cout = (op_q == OpSub) ? diff9[8] : sum9[8];
        case (op_q)
            OpAdd:   alu_res = sum9[7:0];
            OpSub:   alu_res = diff9[7:0];
            OpAnd:   alu_res = a_q & b_q;
            OpOr:    alu_res = a_q | b_q;
            OpXor:   alu_res = a_q ^ b_q;
            default: alu_res = 8'h00;
        endcase
    end

    logic [7:0] res_d;
    logic       cout_d, ovf_d, err_d;

    always_comb begin
        res_d  = alu_res;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        err_d  = 1'b0;
        case (op_q)
            OpAdd: begin
                cout_d = alu_cout;
                ovf_d  = alu_ovf;
            end
            OpSub: begin
                cout_d = alu_cout;
                ovf_d  = (a_q[7] ^ b_q[7]) & (alu_res[7] ^ a_q[7]);
            end
            OpAnd, OpOr, OpXor: begin
                cout_d = 1'b0;
                ovf_d  = 1'b0;
            end
            default: begin
                res_d = 8'h00;
                err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            port_q   <= 1'b0;
            last_q   <= 1'b1;
            op_q     <= 3'd0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            result_q <= 8'h00;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            if (accept) begin
                port_q <= gnt_port;
                op_q   <= gnt_port ? req1_op_i : req0_op_i;
                a_q    <= gnt_port ? req1_a_i : req0_a_i;
                b_q    <= gnt_port ? req1_b_i : req0_b_i;
            end
            if (state_q == StExec) begin
                result_q <= res_d;
                cout_q   <= cout_d;
                ovf_q    <= ovf_d;
                err_q    <= err_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances share stimulus and are checked
// every cycle against a latency/transaction model, plus directed literal scenarios.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v0, v1, rr0, rr1;
    logic [2:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;

    logic [1:0] rdy0, rdy1, rv0, rv1, rc, rovf, rerr;
    logic [7:0] rres [2];

    alu_arbiter #(.ArbMode(1'b1)) u_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(v0), .req0_ready_o(rdy0[0]), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0),
        .req1_valid_i(v1), .req1_ready_o(rdy1[0]), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1),
        .rsp0_valid_o(rv0[0]), .rsp0_ready_i(rr0), .rsp1_valid_o(rv1[0]), .rsp1_ready_i(rr1),
        .rsp_result_o(rres[0]), .rsp_cout_o(rc[0]), .rsp_overflow_o(rovf[0]), .rsp_err_o(rerr[0])
    );

    alu_arbiter #(.ArbMode(1'b0)) u_fp (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(v0), .req0_ready_o(rdy0[1]), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0),
        .req1_valid_i(v1), .req1_ready_o(rdy1[1]), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1),
        .rsp0_valid_o(rv0[1]), .rsp0_ready_i(rr0), .rsp1_valid_o(rv1[1]), .rsp1_ready_i(rr1),
        .rsp_result_o(rres[1]), .rsp_cout_o(rc[1]), .rsp_overflow_o(rovf[1]), .rsp_err_o(rerr[1])
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input int m, input logic [31:0] act,
                         input logic [31:0] exp);
        string inst;
        inst = (m == 0) ? "rr" : "fp";
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%s]: got 0x%0h, expected 0x%0h (t=%0t)", nm, inst, act, exp, $time);
        end
    endtask

    // Reference ALU: returns {err, overflow, cout, result} from plain integer arithmetic.
    function automatic logic [10:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        int sa, sb, s;
        logic [10:0] r;
        sa = $signed(a);
        sb = $signed(b);
        s = 0;
        r = '0;
        case (op)
            3'd0, 3'd1: begin
                s = (op == 3'd0) ? sa + sb : sa - sb;
                r = {1'b0, (s > 127 || s < -128), s[8], s[7:0]};
            end
            3'd2: r = {3'b000, a & b};
            3'd3: r = {3'b000, a | b};
            3'd4: r = {3'b000, a ^ b};
            default: r = {1'b1, 10'h000};
        endcase
        return r;
    endfunction

    // Model state: an instance is busy from acceptance until its response is consumed;
    // the response is visible from two cycles after the accepting cycle.
    logic        busy [2];
    int          acc [2];
    logic        mport [2];
    logic        mlast [2];
    logic [10:0] eout [2];
    int          cyc = 0;
    logic        chk_en = 1'b0;

    function automatic int grant(input int m);
        if (v0 && v1) return (m == 0 && mlast[0] == 1'b0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic logic resp_due(input int m);
        return busy[m] && (cyc >= acc[m] + 2);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                busy[m]  <= 1'b0;
                mlast[m] <= 1'b1;
            end else if (!busy[m]) begin
                if (grant(m) >= 0) begin
                    busy[m]  <= 1'b1;
                    acc[m]   <= cyc;
                    mport[m] <= (grant(m) == 1);
                    eout[m]  <= (grant(m) == 1) ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
                end
            end else if (resp_due(m) && (mport[m] ? rr1 : rr0)) begin
                busy[m]  <= 1'b0;
                mlast[m] <= mport[m];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                check("model req0_ready", m, rdy0[m], !busy[m] && grant(m) == 0);
                check("model req1_ready", m, rdy1[m], !busy[m] && grant(m) == 1);
                check("model rsp0_valid", m, rv0[m], resp_due(m) && !mport[m]);
                check("model rsp1_valid", m, rv1[m], resp_due(m) && mport[m]);
                if (resp_due(m)) begin
                    check("model result", m, rres[m], eout[m][7:0]);
                    check("model cout", m, rc[m], eout[m][8]);
                    check("model overflow", m, rovf[m], eout[m][9]);
                    check("model err", m, rerr[m], eout[m][10]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic vld, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        if (p == 0) begin
            v0 = vld; op0 = op; a0 = a; b0 = b;
        end else begin
            v1 = vld; op1 = op; a1 = a; b1 = b;
        end
    endtask

    task automatic wait_hs(input int m, input int p);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p == 0 ? (rdy0[m] & v0) : (rdy1[m] & v1)) begin
                ok = 1'b1;
                break;
            end
        end
        check("handshake seen", m, ok, 1);
    endtask

    task automatic check_reset_vals(input string nm);
        for (int m = 0; m < 2; m++) begin
            check({nm, " rdy0"}, m, rdy0[m], 0);
            check({nm, " rdy1"}, m, rdy1[m], 0);
            check({nm, " rsp0_valid"}, m, rv0[m], 0);
            check({nm, " rsp1_valid"}, m, rv1[m], 0);
            check({nm, " result"}, m, rres[m], 0);
            check({nm, " cout"}, m, rc[m], 0);
            check({nm, " overflow"}, m, rovf[m], 0);
            check({nm, " err"}, m, rerr[m], 0);
        end
    endtask

    task automatic run_one(input int p, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] xr, input logic xc,
                           input logic xv, input logic xe, input string nm);
        tick();
        drive(p, 1'b1, op, a, b);
        rr0 = 1'b1;
        rr1 = 1'b1;
        wait_hs(0, p);
        tick();
        drive(p, 1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        check({nm, " valid one cycle after accept"}, 0, (p == 0) ? rv0[0] : rv1[0], 0);
        @(negedge clk);
        check({nm, " valid two cycles after accept"}, 0, (p == 0) ? rv0[0] : rv1[0], 1);
        check({nm, " other port valid"}, 0, (p == 0) ? rv1[0] : rv0[0], 0);
        check({nm, " result"}, 0, rres[0], xr);
        check({nm, " cout"}, 0, rc[0], xc);
        check({nm, " overflow"}, 0, rovf[0], xv);
        check({nm, " err"}, 0, rerr[0], xe);
        tick();
    endtask

    int glog_rr[$];
    int glog_fp[$];

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        check_reset_vals("after reset");
        tick();
        rst_n = 1'b1;

        run_one(0, 3'd0, 8'd100, 8'd50, 8'h96, 1'b0, 1'b1, 1'b0, "add0 100+50");
        run_one(1, 3'd1, 8'h80, 8'd1, 8'h7F, 1'b1, 1'b1, 1'b0, "sub1 -128-1");
        run_one(0, 3'd1, 8'd5, 8'd10, 8'hFB, 1'b1, 1'b0, 1'b0, "sub0 5-10");
        run_one(0, 3'd6, 8'd12, 8'd34, 8'h00, 1'b0, 1'b0, 1'b1, "undef op");

        // Both ports continuously valid from a fresh reset.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(0, 1'b1, 3'd0, 8'd1, 8'd1);
        drive(1, 1'b1, 3'd4, 8'hF0, 8'hFF);
        rr0 = 1'b1;
        rr1 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (rdy0[0]) glog_rr.push_back(0);
            if (rdy1[0]) glog_rr.push_back(1);
            if (rdy0[1]) glog_fp.push_back(0);
            if (rdy1[1]) glog_fp.push_back(1);
            if (rv1[0]) begin
                check("xor result", 0, rres[0], 8'h0F);
                check("xor cout", 0, rc[0], 0);
                check("xor overflow", 0, rovf[0], 0);
            end
            if (rv0[0]) check("add 1+1 result", 0, rres[0], 8'h02);
        end
        tick();
        drive(0, 1'b0, 3'd0, 8'h00, 8'h00);
        drive(1, 1'b0, 3'd0, 8'h00, 8'h00);
        repeat (4) tick();
        check("rr grant count", 0, glog_rr.size() >= 4, 1);
        check("fp grant count", 1, glog_fp.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < glog_rr.size()) check($sformatf("rr grant %0d", i), 0, glog_rr[i], i % 2);
            if (i < glog_fp.size()) check($sformatf("fp grant %0d", i), 1, glog_fp[i], 0);
        end

        // Response stall with a competing request pending.
        tick();
        rr0 = 1'b0;
        drive(0, 1'b1, 3'd2, 8'hCC, 8'hAA);
        wait_hs(0, 0);
        tick();
        drive(0, 1'b0, 3'd0, 8'h00, 8'h00);
        drive(1, 1'b1, 3'd0, 8'd1, 8'd1);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall rsp0_valid", 0, rv0[0], 1);
            check("stall result", 0, rres[0], 8'h88);
            check("stall cout", 0, rc[0], 0);
            check("stall overflow", 0, rovf[0], 0);
            check("stall rdy0", 0, rdy0[0], 0);
            check("stall rdy1", 0, rdy1[0], 0);
        end
        tick();
        rr0 = 1'b1;
        wait_hs(0, 1);
        tick();
        drive(1, 1'b0, 3'd0, 8'h00, 8'h00);
        repeat (4) tick();

        // Reset while the operation is in EXEC.
        drive(1, 1'b1, 3'd1, 8'd3, 8'd1);
        rr1 = 1'b1;
        wait_hs(0, 1);
        tick();
        drive(1, 1'b0, 3'd0, 8'h00, 8'h00);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset in exec");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no response after reset", 0, rv1[0], 0);
        end

        for (int i = 0; i < 3000; i++) begin
            tick();
            drive(0, $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
                  8'($urandom));
            drive(1, $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
                  8'($urandom));
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
        end
        tick();
        rst_n = 1'b1;
        drive(0, 1'b0, 3'd0, 8'h00, 8'h00);
        drive(1, 1'b0, 3'd0, 8'h00, 8'h00);
        rr0 = 1'b1;
        rr1 = 1'b1;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
